// File: rtl/deca_oci_trace_capture_pkg.sv
// Shared definitions for the DECA OCI trace capture block.
// - state_e        : capture FSM encoding (also driven out on the state port)
// - *_DEF          : default frame/count/depth geometry
// - entry_w()      : width of one stored FIFO entry {count, frame}
package deca_oci_trace_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam int FRAME_W_DEF = 30;
  localparam int CNT_W_DEF   = 4;
  localparam int DEPTH_DEF   = 16;

  function automatic int entry_w(input int frame_w, input int cnt_w);
    return frame_w + cnt_w;
  endfunction

endpackage

// File: rtl/deca_oci_trace_fifo.sv
// First-word-fall-through FIFO with a registered head-of-queue output.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   push, wdata  : write request and data (accepted when not full, or when
//                  a pop happens in the same cycle)
//   pop          : read request (ignored when empty)
//   rdata        : registered copy of the head entry
//   full, empty  : occupancy flags
//   level        : number of entries held (0..DEPTH)
module deca_oci_trace_fifo
  import deca_oci_trace_capture_pkg::*;
#(
  parameter int WIDTH = entry_w(FRAME_W_DEF, CNT_W_DEF),
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [LVL_W-1:0] level_q, level_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             do_push, do_pop;

  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign rdata = rdata_q;

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    do_pop     = pop && !empty;
    do_push    = push && (!full || do_pop);
    rd_ptr_nxt = rd_ptr_q + PTR_W'(1);
    wr_ptr_d   = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = do_pop ? rd_ptr_nxt : rd_ptr_q;
    level_d    = level_q;
    rdata_d    = rdata_q;

    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    // Keep rdata_q equal to the entry that will be at the head next cycle.
    // When the queue is (or becomes) empty the incoming word bypasses the
    // array, since it is written at the same edge it must appear.
    if (do_pop) begin
      if (level_q == LVL_W'(1)) begin
        if (do_push) rdata_d = wdata;
      end else begin
        rdata_d = mem_q[rd_ptr_nxt];
      end
    end else if (empty && do_push) begin
      rdata_d = wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      rdata_q  <= rdata_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; level/pointers define
  // which words are valid, and a reset-free array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/deca_oci_trace_capture.sv
// Trace capture controller: arms on request, captures non-empty trace frames
// into a FWFT FIFO, drains on test_ending, and parks in DONE.
// Ports:
//   clk, reset_n     : clock, asynchronous-assert active-low reset
//   arm              : start capture (IDLE only)
//   dct_buffer/count : trace frame and its entry count (count!=0 = present)
//   test_ending      : stop capturing and drain
//   test_has_ended   : force DONE next cycle from any state
//   rd_ready         : consumer accepts rd_data
//   rd_valid/rd_data : FIFO head {count, frame}
//   fill_level       : entries held
//   overflow_cnt     : saturating count of frames dropped while full
//   state, done      : FSM state and DONE indicator
module deca_oci_trace_capture
  import deca_oci_trace_capture_pkg::*;
#(
  parameter int FRAME_W = FRAME_W_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int OVF_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       arm,
  input  logic [FRAME_W-1:0]         dct_buffer,
  input  logic [CNT_W-1:0]           dct_count,
  input  logic                       test_ending,
  input  logic                       test_has_ended,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [CNT_W+FRAME_W-1:0]   rd_data,
  output logic [$clog2(DEPTH+1)-1:0] fill_level,
  output logic [OVF_W-1:0]           overflow_cnt,
  output logic [1:0]                 state,
  output logic                       done
);

  localparam int ENTRY_W = entry_w(FRAME_W, CNT_W);

  // Reset asserts asynchronously but releases on a clock edge, two flops
  // after reset_n rises, so no flop sees a release near its clock edge.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n;

  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign rst_n      = rst_sync_q[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= '0;
    else          rst_sync_q <= rst_sync_d;
  end

  state_e           state_q, state_d;
  logic [OVF_W-1:0] ovf_q, ovf_d;
  logic             push_req, fifo_full, fifo_empty, drop;

  assign push_req = (state_q == ST_CAPTURE) && (dct_count != '0);
  // A frame is dropped only when full and the consumer is not freeing a slot.
  assign drop     = push_req && fifo_full && !(rd_ready && !fifo_empty);

  deca_oci_trace_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push_req),
    .wdata({dct_count, dct_buffer}),
    .pop  (rd_ready),
    .rdata(rd_data),
    .full (fifo_full),
    .empty(fifo_empty),
    .level(fill_level)
  );

  always_comb begin
    state_d = state_q;
    ovf_d   = ovf_q;

    if (test_has_ended) begin
      state_d = ST_DONE;
    end else begin
      unique case (state_q)
        ST_IDLE:    if (arm)         state_d = ST_CAPTURE;
        ST_CAPTURE: if (test_ending) state_d = ST_DRAIN;
        ST_DRAIN:   if (fifo_empty)  state_d = ST_DONE;
        ST_DONE:                     state_d = ST_DONE;
        default:                     state_d = ST_IDLE;
      endcase
    end

    if (drop && (ovf_q != '1)) ovf_d = ovf_q + OVF_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
    end
  end

  assign rd_valid     = !fifo_empty;
  assign overflow_cnt = ovf_q;
  assign state        = state_q;
  assign done         = (state_q == ST_DONE);

endmodule

// File: tb/tb_deca_oci_trace_capture.sv
// Directed self-checking bench for deca_oci_trace_capture (default geometry:
// FRAME_W=30, CNT_W=4, DEPTH=16, OVF_W=16). Inputs change 1 time unit after
// a rising edge and outputs are sampled at that same point.
module tb_deca_oci_trace_capture;

  localparam int FRAME_W = 30;
  localparam int CNT_W   = 4;
  localparam int DEPTH   = 16;
  localparam int OVF_W   = 16;

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic                     arm;
  logic [FRAME_W-1:0]       dct_buffer;
  logic [CNT_W-1:0]         dct_count;
  logic                     test_ending;
  logic                     test_has_ended;
  logic                     rd_ready;
  logic                     rd_valid;
  logic [CNT_W+FRAME_W-1:0] rd_data;
  logic [4:0]               fill_level;
  logic [OVF_W-1:0]         overflow_cnt;
  logic [1:0]               state;
  logic                     done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  deca_oci_trace_capture #(
    .FRAME_W(FRAME_W), .CNT_W(CNT_W), .DEPTH(DEPTH), .OVF_W(OVF_W)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .arm           (arm),
    .dct_buffer    (dct_buffer),
    .dct_count     (dct_count),
    .test_ending   (test_ending),
    .test_has_ended(test_has_ended),
    .rd_ready      (rd_ready),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .fill_level    (fill_level),
    .overflow_cnt  (overflow_cnt),
    .state         (state),
    .done          (done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ent(input logic [3:0] c, input logic [29:0] f);
    return {30'd0, c, f};
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, state, 0);
    check({tag, "_fill"}, fill_level, 0);
    check({tag, "_rd_valid"}, rd_valid, 0);
    check({tag, "_rd_data"}, rd_data, 0);
    check({tag, "_ovf"}, overflow_cnt, 0);
    check({tag, "_done"}, done, 0);
  endtask

  // Assert reset off-edge, check outputs immediately, release and let the
  // internal synchroniser deassert.
  task automatic do_reset(input string tag);
    #1 reset_n = 1'b0;
    #1 check_reset_outputs(tag);
    tick();
    reset_n = 1'b1;
    tick(); tick(); tick();
  endtask

  initial begin
    reset_n = 1'b0; arm = 1'b0; dct_buffer = '0; dct_count = '0;
    test_ending = 1'b0; test_has_ended = 1'b0; rd_ready = 1'b0;
    tick(); tick();
    check_reset_outputs("por");
    reset_n = 1'b1;
    tick(); tick(); tick();
    check("idle_no_arm", state, 0);

    // Basic capture with streaming consumer.
    arm = 1'b1; tick(); arm = 1'b0;
    check("armed", state, 1);
    rd_ready = 1'b1; dct_count = 4'd5;
    dct_buffer = 30'h1; tick();
    check("f1_valid", rd_valid, 1);
    check("f1_data", rd_data, ent(4'd5, 30'h1));
    dct_buffer = 30'h2; tick();
    check("f2_data", rd_data, ent(4'd5, 30'h2));
    check("f2_fill", fill_level, 1);
    dct_buffer = 30'h3; tick();
    check("f3_data", rd_data, ent(4'd5, 30'h3));
    dct_count = 4'd0; tick();
    check("stream_empty_valid", rd_valid, 0);
    check("stream_empty_fill", fill_level, 0);
    tick();
    check("empty_ready_fill", fill_level, 0);

    // Overflow: 20 frames into a 16-deep FIFO with no consumer.
    rd_ready = 1'b0; dct_count = 4'd9;
    for (int i = 0; i < 20; i++) begin
      dct_buffer = 30'(100 + i);
      tick();
    end
    check("ovf_fill", fill_level, 16);
    check("ovf_cnt", overflow_cnt, 4);
    check("ovf_head", rd_data, ent(4'd9, 30'd100));
    dct_count = 4'd0; tick();
    check("ovf_zero_count_ignored", overflow_cnt, 4);

    // Full with simultaneous push and pop.
    rd_ready = 1'b1; dct_count = 4'd9; dct_buffer = 30'h200; tick();
    check("fullpp_fill", fill_level, 16);
    check("fullpp_ovf", overflow_cnt, 4);
    dct_count = 4'd0;
    for (int i = 1; i < 16; i++) begin
      check($sformatf("rb_%0d", i), rd_data, ent(4'd9, 30'(100 + i)));
      tick();
    end
    check("rb_last", rd_data, ent(4'd9, 30'h200));
    tick();
    check("rb_empty", fill_level, 0);
    check("rb_state", state, 1);

    // Drain: 4 held, test_ending with a frame.
    rd_ready = 1'b0; dct_count = 4'd3;
    for (int i = 0; i < 4; i++) begin
      dct_buffer = 30'(12'h300 + i);
      tick();
    end
    dct_buffer = 30'h304; test_ending = 1'b1; tick();
    test_ending = 1'b0;
    check("drain_state", state, 2);
    check("drain_fill", fill_level, 5);
    dct_buffer = 30'h3ff; tick();
    check("drain_no_push", fill_level, 5);
    dct_count = 4'd0; rd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("drain_rd_%0d", i), rd_data, ent(4'd3, 30'(12'h300 + i)));
      tick();
    end
    check("drain_empty_fill", fill_level, 0);
    check("drain_empty_state", state, 2);
    check("drain_not_done", done, 0);
    tick();
    check("done_state", state, 3);
    check("done_flag", done, 1);
    arm = 1'b1; tick(); arm = 1'b0;
    check("done_ignores_arm", state, 3);

    // Forced end in CAPTURE with 7 held.
    do_reset("rst1");
    arm = 1'b1; tick(); arm = 1'b0;
    rd_ready = 1'b0; dct_count = 4'd7;
    for (int i = 0; i < 7; i++) begin
      dct_buffer = 30'(12'h400 + i);
      tick();
    end
    dct_count = 4'd0; test_has_ended = 1'b1; test_ending = 1'b1; tick();
    test_has_ended = 1'b0; test_ending = 1'b0;
    check("forced_state", state, 3);
    check("forced_fill", fill_level, 7);
    dct_count = 4'd7; dct_buffer = 30'h4ff; tick();
    check("forced_ignored_fill", fill_level, 7);
    check("forced_ignored_ovf", overflow_cnt, 0);
    dct_count = 4'd0; rd_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      check($sformatf("forced_rd_%0d", i), rd_data, ent(4'd7, 30'(12'h400 + i)));
      tick();
    end
    check("forced_empty", fill_level, 0);

    // Reset mid-DRAIN with 9 held.
    do_reset("rst2");
    arm = 1'b1; tick(); arm = 1'b0;
    rd_ready = 1'b0; dct_count = 4'd2;
    for (int i = 0; i < 9; i++) begin
      dct_buffer = 30'(12'h500 + i);
      tick();
    end
    dct_count = 4'd0; test_ending = 1'b1; tick(); test_ending = 1'b0;
    check("pre_rst_state", state, 2);
    check("pre_rst_fill", fill_level, 9);
    check("pre_rst_head", rd_data, ent(4'd2, 30'h500));
    do_reset("rst_drain");
    check("post_rst_state", state, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/deca_oci_trace_capture.md
DECA_OCI_TRACE_CAPTURE -- requirements
Module: deca_oci_trace_capture

Interface
REQ-001 Parameter FRAME_W, 30: width of dct_buffer trace frame.
REQ-002 Parameter CNT_W, 4: width of dct_count.
REQ-003 Parameter DEPTH, 16: FIFO entries; power of two, 2..256.
REQ-004 Parameter OVF_W, 16: overflow counter width.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-007 arm  in  1  start-capture pulse.
REQ-008 dct_buffer  in  FRAME_W  packed trace frame.
REQ-009 dct_count  in  CNT_W  valid entries in frame; nonzero marks frame present.
REQ-010 test_ending  in  1  pulse: stop capture, begin drain.
REQ-011 test_has_ended  in  1  level: force terminal state.
REQ-012 rd_ready  in  1  consumer accepts rd_data.
REQ-013 rd_valid  out  1  rd_data holds an unread entry.
REQ-014 rd_data  out  CNT_W+FRAME_W  {count, frame} of FIFO head.
REQ-015 fill_level  out  clog2(DEPTH+1)  entries held.
REQ-016 overflow_cnt  out  OVF_W  frames dropped while full.
REQ-017 state  out  2  IDLE=0, CAPTURE=1, DRAIN=2, DONE=3.
REQ-018 done  out  1  high iff state==DONE.

Function
REQ-019 IDLE->CAPTURE on arm; arm ignored in other states.
REQ-020 CAPTURE: push {dct_count,dct_buffer} each cycle dct_count!=0 and (not full or pop same cycle).
REQ-021 CAPTURE->DRAIN on test_ending; a frame presented that cycle is still pushed.
REQ-022 DRAIN: no pushes; DRAIN->DONE the cycle after fill_level reaches 0.
REQ-023 test_has_ended=1 forces DONE next cycle from any state, priority over test_ending and arm; pushes that cycle still occur if in CAPTURE.
REQ-024 DONE terminal until reset; pops continue in DONE.
REQ-025 Pop when rd_valid && rd_ready; rd_valid = fill_level!=0; first-word-fall-through.
REQ-026 Push-to-rd_valid latency exactly 1 cycle; rd_data registered.
REQ-027 Full and push without pop: frame dropped, overflow_cnt +1, saturating at all-ones.
REQ-028 Full with simultaneous push and pop: both succeed, fill_level unchanged, no overflow.
REQ-029 Empty with rd_ready: no pop, fill_level stays 0.
REQ-030 Pointers wrap modulo DEPTH; fill_level never exceeds DEPTH.
REQ-031 Frames with dct_count==0 never pushed, never counted as overflow.

Reset
REQ-032 reset_n low: state=IDLE, pointers 0, fill_level=0, rd_valid=0, rd_data=0, overflow_cnt=0, done=0.
REQ-033 Reset mid-operation discards FIFO contents and counts immediately; release synchronised to clk.

Structure
REQ-034 Shared package: state enum, default FRAME_W/CNT_W/DEPTH constants, entry-width function.
REQ-035 One sub-module deca_oci_trace_fifo (parametrised FWFT FIFO, push/pop/full/empty/level); FSM and overflow counter in top.
REQ-036 Storage inferred as registers or simple dual-port RAM; no vendor primitives.

Verification
REQ-037 Reset, arm, 3 frames count=5 data 0x1,0x2,0x3, rd_ready=1 -> rd_data 0x5_00000001..3 in order, each 1 cycle after push.
REQ-038 DEPTH=16, rd_ready=0, 20 frames -> fill_level=16, overflow_cnt=4, first 16 frames read back intact.
REQ-039 Full, push+pop same cycle -> fill_level 16, overflow_cnt unchanged.
REQ-040 CAPTURE with 4 held, test_ending with frame -> DRAIN, 5 popped, done=1 cycle after empty.
REQ-041 test_has_ended in CAPTURE with 7 held -> DONE next cycle, 7 still readable, later frames ignored.
REQ-042 reset_n low mid-DRAIN with 9 held -> all outputs reset values same cycle; state IDLE.
